raster_focal_stream: RTL and testbench
======================================

Name: raster_focal_stream

Overview:
- Streaming 2x2 focal-window operator over a row-major raster of IMG_W x IMG_H pixels of PIX_W bits.
- Parametrised successor of the team's single-shot combinational four-cell focal mean.
- Adds a one-row line buffer, frame row/column tracking, a selectable reduction mode and valid/ready handshakes on both sides.
- Sits between the SPU pixel input stream and the result output stream.

Parameters:
- PIX_W, 4: input pixel width in bits; >=2.
- IMG_W, 8: pixels per raster row; >=2.
- IMG_H, 8: rows per frame; >=2.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- mode  in  2  reduction: 00 mean, 01 sum, 10 min, 11 max; sampled at frame start.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_pixel  in  PIX_W  pixel value, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  PIX_W+2  focal result, unsigned, zero-extended where narrower.
- out_last  out  1  asserted with the final result of a frame.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_data=0, out_last=0.
  - Column and row counters = 0, line buffer and delay registers = 0, latched mode = 00.
  - in_ready=1 the first cycle after reset.
  - Reset mid-frame discards the partial frame. The next accepted pixel is (row 0, col 0).
- Accept: a pixel is taken when in_valid & in_ready.
  - in_ready = !out_valid | out_ready, so there is a single output stage and no bubble under continuous flow.
- Position:
  - col increments on each accept and wraps IMG_W-1 -> 0, incrementing row.
  - row wraps IMG_H-1 -> 0, starting a new frame.
  - mode is latched on accept of pixel (0,0) and held for the whole frame. Mode changes mid-frame are ignored.
- Window storage: a delay line of IMG_W+1 pixels, shifted only on accept. For the pixel accepted at (r,c), the window is:
  - P (r,c) = current pixel
  - L (r,c-1) = delay 1
  - U (r-1,c) = delay IMG_W
  - UL (r-1,c-1) = delay IMG_W+1
- Emit: only when r>=1 and c>=1, giving (IMG_H-1)*(IMG_W-1) results per frame.
  - Accepts at row 0 or col 0 update storage but produce no output.
- Result, computed at PIX_W+2 bits with no overflow:
  - sum = P+L+U+UL
  - mean = floor(sum/4)
  - min / max = smallest / largest of the four.
- Latency: out_valid rises the cycle after the accepting edge.
  - out_data and out_last stay stable while out_valid & !out_ready.
  - out_valid clears after a handshake unless a new result is loaded the same edge.
- Simultaneous out handshake and new accept: the new result replaces the old at that edge and out_valid stays 1.
- out_last = 1 only for the result of pixel (IMG_H-1, IMG_W-1).
- Back-to-back frames: row 0 of the next frame reuses storage. No cross-frame output, because row 0 never emits.
- in_valid=0: state frozen, with no shift and no counter change.

Test Plan:
- Ramp, PIX_W=4, IMG_W=4, IMG_H=3, mode=00, pixels 0..11, out_ready=1 -> 6 results: 2,3,4,6,7,8. out_last only on the 6th.
- Same stimulus with mode=01 -> results 10,14,18,26,30,34.
- All pixels 15, mode=01 then mode=00 -> every result 60 / 15, with no truncation at the PIX_W+2 boundary.
- Frame of values alternating 3,9 by column, mode=10 then 11 -> all results 3 (min) / 9 (max).
- out_ready held 0 after the first result -> in_ready drops to 0, out_data holds 2 for 5 cycles. Releasing it resumes the sequence with no lost or duplicated results.
- Assert rst_n=0 after 6 pixels, then send a full frame with mode toggled at pixel 5 -> exactly 6 correct results (no stale window data) in the mode sampled at (0,0).

Source files
------------

// File: rtl/raster_focal_stream_if.sv
// Handshake bundle for the streaming 2x2 focal operator: pixel input side,
// result output side and the frame reduction-mode select.
interface raster_focal_stream_if #(
  parameter int PIX_W = 4
);
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W+1:0] out_data;
  logic             out_last;

  modport master (
    output mode, in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  mode, in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/raster_focal_stream.sv
// Streaming 2x2 focal-window reducer (mean/sum/min/max) over a row-major raster,
// using an IMG_W+1 deep delay line and a single registered output stage.
module raster_focal_stream #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  raster_focal_stream_if.slave  bus
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int OW = PIX_W + 2;

  // Window reduction, widened to OW bits so the sum of four pixels never overflows.
  function automatic logic [OW-1:0] focal_reduce(
    input logic [PIX_W-1:0] p,
    input logic [PIX_W-1:0] l,
    input logic [PIX_W-1:0] u,
    input logic [PIX_W-1:0] ul,
    input logic [1:0]       m
  );
    logic [OW-1:0]    sum;
    logic [PIX_W-1:0] mn_a, mn_b, mx_a, mx_b, mn, mx;
    sum  = {2'b00, p} + {2'b00, l} + {2'b00, u} + {2'b00, ul};
    mn_a = (p < l) ? p : l;
    mn_b = (u < ul) ? u : ul;
    mx_a = (p > l) ? p : l;
    mx_b = (u > ul) ? u : ul;
    mn   = (mn_a < mn_b) ? mn_a : mn_b;
    mx   = (mx_a > mx_b) ? mx_a : mx_b;
    case (m)
      2'b00:   focal_reduce = {2'b00, sum[OW-1:2]};
      2'b01:   focal_reduce = sum;
      2'b10:   focal_reduce = {2'b00, mn};
      2'b11:   focal_reduce = {2'b00, mx};
      default: focal_reduce = {OW{1'b0}};
    endcase
  endfunction

  logic [CW-1:0]    col_r;
  logic [RW-1:0]    row_r;
  logic [1:0]       mode_r;
  logic [PIX_W-1:0] dly_r [0:IMG_W];
  logic             out_valid_r;
  logic [OW-1:0]    out_data_r;
  logic             out_last_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             col_end_s;
  logic             row_end_s;
  logic             frame_start_s;
  logic             emit_s;
  logic [OW-1:0]    result_s;

  assign in_ready_s    = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

  // Accept/emit qualification and the window result for the pixel on the bus.
  always_comb begin
    accept_s      = bus.in_valid && in_ready_s;
    col_end_s     = (col_r == CW'(IMG_W - 1));
    row_end_s     = (row_r == RW'(IMG_H - 1));
    frame_start_s = (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
    emit_s        = accept_s && (col_r != {CW{1'b0}}) && (row_r != {RW{1'b0}});
    result_s      = focal_reduce(bus.in_pixel, dly_r[0], dly_r[IMG_W-1], dly_r[IMG_W], mode_r);
  end

  // Raster position, frame mode latch and delay line; all advance only on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r  <= {CW{1'b0}};
      row_r  <= {RW{1'b0}};
      mode_r <= 2'b00;
      for (int i = 0; i <= IMG_W; i++) begin
        dly_r[i] <= {PIX_W{1'b0}};
      end
    end else if (accept_s) begin
      dly_r[0] <= bus.in_pixel;
      for (int i = 1; i <= IMG_W; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
      if (frame_start_s) begin
        mode_r <= bus.mode;
      end
      if (col_end_s) begin
        col_r <= {CW{1'b0}};
        row_r <= row_end_s ? {RW{1'b0}} : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Single output stage: a new result overwrites on the same edge as a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OW{1'b0}};
      out_last_r  <= 1'b0;
    end else if (emit_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
      out_last_r  <= col_end_s && row_end_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raster_focal_stream.sv
// Directed self-checking bench for raster_focal_stream on a 4x3 raster of 4-bit pixels.
module tb_raster_focal_stream;

  localparam int PIX_W = 4;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   data_q[$];
  bit   last_q[$];
  int   vals[12];
  int   exp_a[6];

  raster_focal_stream_if #(.PIX_W(PIX_W)) bus_if ();

  raster_focal_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so the negedge sees the handshake about to happen.
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      data_q.push_back(int'(bus_if.out_data));
      last_q.push_back(bus_if.out_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] v, input logic [1:0] m);
    bit done;
    int n;
    bus_if.in_valid = 1'b1;
    bus_if.in_pixel = v;
    bus_if.mode     = m;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      done = bus_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check_val("send_accept", int'(done), 1);
  endtask

  task automatic drain();
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int v[12], input logic [1:0] m);
    for (int i = 0; i < 12; i++) send(4'(v[i]), m);
    drain();
  endtask

  task automatic check_results(input string tag, input int exp[6]);
    check_val({tag, "_count"}, data_q.size(), 6);
    for (int i = 0; i < 6 && i < data_q.size(); i++) begin
      check_val({tag, "_data"}, data_q[i], exp[i]);
      check_val({tag, "_last"}, int'(last_q[i]), (i == 5) ? 1 : 0);
    end
    data_q.delete();
    last_q.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_pixel  = 4'd0;
    bus_if.mode      = 2'b00;
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", int'(bus_if.out_valid), 0);
    check_val("rst_out_data", int'(bus_if.out_data), 0);
    check_val("rst_out_last", int'(bus_if.out_last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_in_ready", int'(bus_if.in_ready), 1);

    // Ramp frame, mean then sum.
    for (int i = 0; i < 12; i++) vals[i] = i;
    send_frame(vals, 2'b00);
    exp_a = '{2, 3, 4, 6, 7, 8};
    check_results("ramp_mean", exp_a);
    send_frame(vals, 2'b01);
    exp_a = '{10, 14, 18, 26, 30, 34};
    check_results("ramp_sum", exp_a);

    // Full-scale pixels exercise the widest sum.
    for (int i = 0; i < 12; i++) vals[i] = 15;
    send_frame(vals, 2'b01);
    exp_a = '{60, 60, 60, 60, 60, 60};
    check_results("full_sum", exp_a);
    send_frame(vals, 2'b00);
    exp_a = '{15, 15, 15, 15, 15, 15};
    check_results("full_mean", exp_a);

    // Column-alternating 3/9, min then max.
    for (int i = 0; i < 12; i++) vals[i] = (i % 2 == 0) ? 3 : 9;
    send_frame(vals, 2'b10);
    exp_a = '{3, 3, 3, 3, 3, 3};
    check_results("alt_min", exp_a);
    send_frame(vals, 2'b11);
    exp_a = '{9, 9, 9, 9, 9, 9};
    check_results("alt_max", exp_a);

    // Backpressure after the first result of a ramp frame.
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(4'(i), 2'b00);
    bus_if.in_pixel = 4'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("stall_in_ready", int'(bus_if.in_ready), 0);
      check_val("stall_out_valid", int'(bus_if.out_valid), 1);
      check_val("stall_out_data", int'(bus_if.out_data), 2);
    end
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b1;
    for (int i = 6; i < 12; i++) send(4'(i), 2'b00);
    drain();
    exp_a = '{2, 3, 4, 6, 7, 8};
    check_results("stall_ramp", exp_a);

    // Reset after six pixels, then a frame whose mode input changes mid-frame.
    for (int i = 0; i < 6; i++) send(4'd15, 2'b11);
    bus_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("midrst_out_valid", int'(bus_if.out_valid), 0);
    data_q.delete();
    last_q.delete();
    for (int i = 0; i < 12; i++) send(4'(i), (i < 5) ? 2'b01 : 2'b10);
    drain();
    exp_a = '{10, 14, 18, 26, 30, 34};
    check_results("midrst_sum", exp_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
